// File: rtl/prime_seq_ctrl.sv
// prime_seq_ctrl
// Sequencing controller for the trial-division primality datapath. It reads
// n/rem/div from the operand/result register block and drives that block's
// load strobes and next-value buses. Divisors 2,3,4,... are tried by repeated
// subtraction until div*div exceeds n. The square is tracked incrementally in
// sq_q, so no multiplier is needed.
module prime_seq_ctrl #(
   parameter int W  = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  n_i,
   input  logic [W-1:0]  rem_i,
   input  logic [W-1:0]  div_i,
   output logic          remld_o,
   output logic [W-1:0]  remi_o,
   output logic          divld_o,
   output logic [W-1:0]  divi_o,
   output logic          resld_o,
   output logic          resi_o,
   output logic          done_o,
   output logic [CW-1:0] cycles_o
);

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      CHECK = 2'd1,
      SUB   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2*W-1:0]    sq_q, sq_d;
   logic [CW-1:0]     cycles_q;
   logic [2*W-1:0]    nExt;
   logic [2*W-1:0]    divExt;

   assign nExt   = {{W{1'b0}}, n_i};
   assign divExt = {{W{1'b0}}, div_i};

   // The register block sees its reset on the same edge, so the count reads zero while rst is high
   assign cycles_o = rst ? '0 : cycles_q;

   // Mealy decode of state plus register-block values; everything is forced quiet while rst is high
   always_comb begin
      state_d = state_q;
      sq_d    = sq_q;
      remld_o = 1'b0;
      remi_o  = '0;
      divld_o = 1'b0;
      divi_o  = '0;
      resld_o = 1'b0;
      resi_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         INIT: begin
            if (n_i < W'(2)) begin
               resld_o = 1'b1;
               resi_o  = 1'b0;
               state_d = DONE;
            end else begin
               divld_o = 1'b1;
               divi_o  = W'(2);
               sq_d    = (2*W)'(4);
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (sq_q > nExt) begin
               state_d = DONE;
            end else begin
               remld_o = 1'b1;
               remi_o  = n_i;
               state_d = SUB;
            end
         end
         SUB: begin
            if (rem_i >= div_i) begin
               remld_o = 1'b1;
               remi_o  = rem_i - div_i;
            end else if (rem_i == '0) begin
               resld_o = 1'b1;
               resi_o  = 1'b0;
               state_d = DONE;
            end else begin
               divld_o = 1'b1;
               divi_o  = div_i + W'(1);
               sq_d    = sq_q + (divExt << 1) + (2*W)'(1);
               state_d = CHECK;
            end
         end
         default: begin
            done_o = 1'b1;
         end
      endcase
      if (rst) begin
         state_d = INIT;
         sq_d    = '0;
         remld_o = 1'b0;
         remi_o  = '0;
         divld_o = 1'b0;
         divi_o  = '0;
         resld_o = 1'b0;
         resi_o  = 1'b0;
         done_o  = 1'b0;
      end
   end

   // State, running square and saturating busy-cycle counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= INIT;
         sq_q     <= '0;
         cycles_q <= '0;
      end else begin
         state_q <= state_d;
         sq_q    <= sq_d;
         if ((state_q != DONE) && (cycles_q != '1)) begin
            cycles_q <= cycles_q + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_prime_seq_ctrl.sv
// tb_prime_seq_ctrl
// Drives prime_seq_ctrl together with a behavioural model of the register
// block, and compares the outcome of each run against a plain trial-division
// reference computed from the arithmetic rules of the algorithm.
module tb_prime_seq_ctrl;

   localparam int W      = 16;
   localparam int CW     = 8;
   localparam int BUDGET = 20000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  n = '0;
   logic [W-1:0]  rem;
   logic [W-1:0]  div;
   logic          result;
   logic          remld, divld, resld, resi, done;
   logic [W-1:0]  remi, divi;
   logic [CW-1:0] cycles;

   int checks = 0;
   int errors = 0;
   int remPulses = 0;
   int divPulses = 0;
   int resPulses = 0;
   int multiStrobe = 0;

   prime_seq_ctrl #(.W(W), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .n_i      (n),
      .rem_i    (rem),
      .div_i    (div),
      .remld_o  (remld),
      .remi_o   (remi),
      .divld_o  (divld),
      .divi_o   (divi),
      .resld_o  (resld),
      .resi_o   (resi),
      .done_o   (done),
      .cycles_o (cycles)
   );

   always #5 clk = ~clk;

   // Operand/result register block: reset to rem=0, div=0, result=1, then loads on strobes
   always @(posedge clk) begin
      if (rst) begin
         rem    <= '0;
         div    <= '0;
         result <= 1'b1;
      end else begin
         if (remld) rem <= remi;
         if (divld) div <= divi;
         if (resld) result <= resi;
      end
   end

   // Strobe activity seen by the register block on each active edge
   always @(posedge clk) begin
      if (!rst) begin
         remPulses   = remPulses + int'(remld);
         divPulses   = divPulses + int'(divld);
         resPulses   = resPulses + int'(resld);
         if ((int'(remld) + int'(divld) + int'(resld)) > 1) multiStrobe = multiStrobe + 1;
      end
   end

   // Trial division at the level of the algorithm: each tried divisor d costs one
   // compare cycle, floor(n/d) subtraction cycles and one deciding cycle
   function automatic void refModel(input int nVal, output bit isPrime,
                                    output int finalDiv, output int edges);
      int d;
      if (nVal < 2) begin
         isPrime  = 1'b0;
         finalDiv = 0;
         edges    = 1;
         return;
      end
      edges = 1;
      d     = 2;
      forever begin
         edges = edges + 1;
         if (d * d > nVal) begin
            isPrime  = 1'b1;
            finalDiv = d;
            return;
         end
         edges = edges + nVal / d + 1;
         if (nVal % d == 0) begin
            isPrime  = 1'b0;
            finalDiv = d;
            return;
         end
         d = d + 1;
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clearCounters();
      remPulses   = 0;
      divPulses   = 0;
      resPulses   = 0;
      multiStrobe = 0;
   endtask

   // Hold reset for two edges with a new n, check the quiet reset outputs, then release
   task automatic applyStimulus(input int nVal, input string tag);
      @(negedge clk);
      rst = 1'b1;
      n   = W'(nVal);
      @(negedge clk);
      @(negedge clk);
      checkOutput({tag, ".rstDone"}, 64'(done), 64'd0);
      checkOutput({tag, ".rstCycles"}, 64'(cycles), 64'd0);
      checkOutput({tag, ".rstStrobes"}, 64'({remld, divld, resld}), 64'd0);
      clearCounters();
      rst = 1'b0;
   endtask

   // Wait for done within a cycle budget, then compare against the reference
   task automatic runToDone(input int nVal, input string tag);
      int  edges;
      bit  isPrime;
      int  finalDiv;
      int  expEdges;
      int  expCycles;
      logic [CW-1:0] heldCycles;
      refModel(nVal, isPrime, finalDiv, expEdges);
      expCycles = (expEdges > (2**CW - 1)) ? (2**CW - 1) : expEdges;
      edges = 0;
      while (!done && edges < BUDGET) begin
         @(negedge clk);
         edges = edges + 1;
      end
      checkOutput({tag, ".reachedDone"}, 64'(done), 64'd1);
      checkOutput({tag, ".latency"}, 64'(edges), 64'(expEdges));
      checkOutput({tag, ".cycles"}, 64'(cycles), 64'(expCycles));
      checkOutput({tag, ".result"}, 64'(result), 64'(isPrime));
      checkOutput({tag, ".div"}, 64'(div), 64'(finalDiv));
      checkOutput({tag, ".oneStrobe"}, 64'(multiStrobe), 64'd0);
      if (nVal < 2) begin
         checkOutput({tag, ".remPulses"}, 64'(remPulses), 64'd0);
         checkOutput({tag, ".divPulses"}, 64'(divPulses), 64'd0);
      end
      heldCycles = cycles;
      repeat (3) @(negedge clk);
      checkOutput({tag, ".holdDone"}, 64'(done), 64'd1);
      checkOutput({tag, ".holdCycles"}, 64'(cycles), 64'(heldCycles));
      checkOutput({tag, ".holdStrobes"}, 64'({remld, divld, resld}), 64'd0);
      $display("[TB] n=%0d edges=%0d cycles=%0d result=%0d div=%0d", nVal, edges, cycles, result, div);
   endtask

   task automatic runCase(input int nVal, input string tag);
      applyStimulus(nVal, tag);
      runToDone(nVal, tag);
   endtask

   initial begin
      int nRand;
      $display("[TB] starting prime_seq_ctrl bench");

      runCase(0, "n0");
      runCase(1, "n1");
      runCase(2, "n2");
      runCase(4, "n4");
      runCase(7, "n7");
      runCase(9, "n9");
      runCase(1009, "sat1009");
      runCase(961, "sq961");
      runCase(97, "n97");

      // Reset pulse in the middle of the subtraction loop restarts from scratch
      applyStimulus(91, "midRst");
      repeat (10) @(negedge clk);
      checkOutput("midRst.busy", 64'(done), 64'd0);
      rst = 1'b1;
      #1;
      checkOutput("midRst.strobes", 64'({remld, divld, resld}), 64'd0);
      checkOutput("midRst.done", 64'(done), 64'd0);
      checkOutput("midRst.cycles", 64'(cycles), 64'd0);
      @(negedge clk);
      clearCounters();
      rst = 1'b0;
      runToDone(91, "midRst");

      for (int i = 0; i < 12; i++) begin
         nRand = int'($urandom_range(0, 1500));
         runCase(nRand, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
